// File: rtl/tetris_pkg.sv
// tetris_pkg - shared cell codes, palette and playfield geometry for the board renderer.
// Revision: 1.0
`default_nettype none

package tetris_pkg;

  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int CELLS = COLS * ROWS;

  localparam logic [2:0] CELL_EMPTY = 3'd0;
  localparam logic [2:0] CELL_I     = 3'd1;
  localparam logic [2:0] CELL_O     = 3'd2;
  localparam logic [2:0] CELL_T     = 3'd3;
  localparam logic [2:0] CELL_S     = 3'd4;
  localparam logic [2:0] CELL_Z     = 3'd5;
  localparam logic [2:0] CELL_J     = 3'd6;
  localparam logic [2:0] CELL_L     = 3'd7;

  localparam logic [11:0] COLOR_I     = 12'h0FF;
  localparam logic [11:0] COLOR_O     = 12'hFF0;
  localparam logic [11:0] COLOR_T     = 12'h80F;
  localparam logic [11:0] COLOR_S     = 12'h0F0;
  localparam logic [11:0] COLOR_Z     = 12'hF00;
  localparam logic [11:0] COLOR_J     = 12'h00F;
  localparam logic [11:0] COLOR_L     = 12'hF80;
  localparam logic [11:0] FRAME_COLOR = 12'hFFF;
  localparam logic [11:0] GRID_COLOR  = 12'h333;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  function automatic logic [11:0] cell_color(input logic [2:0] code);
    logic [11:0] c;
    case (code)
      CELL_I:  c = COLOR_I;
      CELL_O:  c = COLOR_O;
      CELL_T:  c = COLOR_T;
      CELL_S:  c = COLOR_S;
      CELL_Z:  c = COLOR_Z;
      CELL_J:  c = COLOR_J;
      CELL_L:  c = COLOR_L;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  // Halve each RGB nibble independently for the bevelled cell border.
  function automatic logic [11:0] darken(input logic [11:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tetris_board_ram.sv
// tetris_board_ram - single-clock playfield store, one write port, one read-first synchronous read port.
// Revision: 1.0
`default_nettype none

module tetris_board_ram #(
  parameter int DEPTH = 200,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [2:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [2:0]    o_rdata
);

  logic [2:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

`default_nettype wire

// File: rtl/tetris_board_renderer.sv
// tetris_board_renderer - composites playfield, frame and background into RGB444 with 2-cycle latency.
// Optional macro GRID_LINES_EN draws a dim grid on empty cell edges.  Revision: 1.0
`default_nettype none

module tetris_board_renderer
  import tetris_pkg::*;
#(
  parameter int BOARD_X0   = 240,
  parameter int BOARD_Y0   = 80,
  parameter int CELL_SHIFT = 4,
  parameter int FRAME_W    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [11:0] bg_color,
  input  logic        wr_en,
  input  logic [4:0]  wr_row,
  input  logic [3:0]  wr_col,
  input  logic [2:0]  wr_cell,
  input  logic        clear_req,
  output logic        busy,
  output logic [11:0] color_out
);

  localparam logic signed [10:0] BRD_W = 11'(COLS << CELL_SHIFT);
  localparam logic signed [10:0] BRD_H = 11'(ROWS << CELL_SHIFT);
  localparam logic signed [10:0] FW    = 11'(FRAME_W);
  localparam logic signed [10:0] X0    = 11'(BOARD_X0);
  localparam logic signed [10:0] Y0    = 11'(BOARD_Y0);

  clr_state_t  r_state;
  logic [7:0]  r_clr_idx;
  logic        r_busy;
  logic        r_in_board;
  logic        r_in_frame;
  logic        r_edge;
  logic [11:0] r_color;

  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic        w_in_board;
  logic        w_in_frame;
  logic        w_edge;
  logic [3:0]  w_col;
  logic [4:0]  w_row;
  logic [7:0]  w_raddr;
  logic        w_wr_ok;
  logic        w_we;
  logic [7:0]  w_waddr;
  logic [2:0]  w_wdata;
  logic [2:0]  w_code;
  logic [11:0] w_pal;
  logic [11:0] w_color;

  // Clear sequencer: busy mirrors the CLEAR state as a registered output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= 8'd0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_idx == 8'(CELLS - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + 8'd1;
          end
        end
        default: begin
          if (clear_req) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= 8'd0;
            r_busy    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign w_wr_ok = wr_en && !r_busy && (wr_row < 5'(ROWS)) && (wr_col < 4'(COLS));
  assign w_we    = (r_state == ST_CLEAR) || w_wr_ok;
  assign w_waddr = (r_state == ST_CLEAR) ? r_clr_idx
                                         : 8'(wr_row) * 8'(COLS) + 8'(wr_col);
  assign w_wdata = (r_state == ST_CLEAR) ? CELL_EMPTY : wr_cell;

  assign w_dx = $signed({1'b0, x}) - X0;
  assign w_dy = $signed({1'b0, y}) - Y0;

  assign w_in_board = (w_dx >= 11'sd0) && (w_dx < BRD_W) &&
                      (w_dy >= 11'sd0) && (w_dy < BRD_H);
  assign w_in_frame = !w_in_board &&
                      (w_dx >= -FW) && (w_dx < BRD_W + FW) &&
                      (w_dy >= -FW) && (w_dy < BRD_H + FW);
  assign w_edge = (&w_dx[CELL_SHIFT-1:0]) || (~|w_dx[CELL_SHIFT-1:0]) ||
                  (&w_dy[CELL_SHIFT-1:0]) || (~|w_dy[CELL_SHIFT-1:0]);

  assign w_col   = w_dx[CELL_SHIFT +: 4];
  assign w_row   = w_dy[CELL_SHIFT +: 5];
  // Off-board pixels read cell 0 so the address never leaves the RAM range.
  assign w_raddr = w_in_board ? 8'(w_row) * 8'(COLS) + 8'(w_col) : 8'd0;

  tetris_board_ram #(
    .DEPTH (CELLS),
    .AW    (8)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_board <= 1'b0;
      r_in_frame <= 1'b0;
      r_edge     <= 1'b0;
    end else begin
      r_in_board <= w_in_board;
      r_in_frame <= w_in_frame;
      r_edge     <= w_edge;
    end
  end

  assign w_pal = cell_color(w_code);

  // bg_color already arrives one cycle behind x,y, so it lines up with the stage-1 flags here.
  always_comb begin
    w_color = bg_color;
    if (r_in_frame) begin
      w_color = FRAME_COLOR;
    end else if (r_in_board && (w_code != CELL_EMPTY)) begin
      w_color = r_edge ? darken(w_pal) : w_pal;
`ifdef GRID_LINES_EN
    end else if (r_in_board && r_edge) begin
      w_color = GRID_COLOR;
`else
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_color <= 12'h000;
    end else begin
      r_color <= w_color;
    end
  end

  assign busy      = r_busy;
  assign color_out = r_color;

endmodule

`default_nettype wire

// File: tb/tb_tetris_board_renderer.sv
// tb_tetris_board_renderer - directed self-checking bench for the board renderer.
// Revision: 1.0
`default_nettype none

module tb_tetris_board_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] bg_color;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [3:0]  wr_col;
  logic [2:0]  wr_cell;
  logic        clear_req;
  logic        busy;
  logic [11:0] color_out;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [2:0] model [200];

  always #5 clk = ~clk;

  tetris_board_renderer dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .bg_color  (bg_color),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_cell   (wr_cell),
    .clear_req (clear_req),
    .busy      (busy),
    .color_out (color_out)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic render(input logic [9:0] px, input logic [9:0] py,
                        input logic [11:0] bg, output logic [11:0] c);
    x = px;
    y = py;
    step;
    bg_color = bg;
    step;
    c = color_out;
  endtask

  task automatic wr(input int row, input int col, input logic [2:0] code);
    wr_en   = 1'b1;
    wr_row  = 5'(row);
    wr_col  = 4'(col);
    wr_cell = code;
    step;
    wr_en = 1'b0;
    if (row < 20 && col < 10) model[row*10 + col] = code;
  endtask

  function automatic logic [11:0] exp_center(input logic [2:0] code, input logic [11:0] bg);
    case (code)
      3'd1:    return 12'h0FF;
      3'd2:    return 12'hFF0;
      3'd3:    return 12'h80F;
      3'd4:    return 12'h0F0;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      3'd7:    return 12'hF80;
      default: return bg;
    endcase
  endfunction

  task automatic count_busy(input int pulse_at, output int n);
    n = 0;
    while (busy && n < 400) begin
      if (n == pulse_at) clear_req = 1'b1;
      if (n == 49 && pulse_at < 0) begin
        wr_en = 1'b1; wr_row = 5'd0; wr_col = 4'd0; wr_cell = 3'd5;
      end
      step;
      clear_req = 1'b0;
      wr_en     = 1'b0;
      n++;
    end
  endtask

  initial begin
    logic [11:0] c;
    int n;
    for (int i = 0; i < 200; i++) model[i] = 3'd0;
    reset = 1'b1; x = '0; y = '0; bg_color = '0;
    wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_cell = '0; clear_req = 1'b0;
    step; step;
    chk("reset_busy", 12'(busy), 12'h001);
    chk("reset_color", color_out, 12'h000);

    reset = 1'b0;
    count_busy(-1, n);
    chk("init_clear_len", 12'(n), 12'd200);
    render(10'd248, 10'd88, 12'h5A5, c);
    chk("busy_write_ignored", c, 12'h5A5);

    wr(0, 0, 3'd1);
    render(10'd245, 10'd85, 12'h000, c);  chk("cell_I_interior", c, 12'h0FF);
    render(10'd240, 10'd80, 12'h000, c);  chk("cell_I_edge", c, 12'h077);
    render(10'd239, 10'd100, 12'hABC, c); chk("frame_left", c, 12'hFFF);
    render(10'd237, 10'd100, 12'hABC, c); chk("outside_left_bg", c, 12'hABC);
    render(10'd238, 10'd78, 12'h111, c);  chk("frame_corner", c, 12'hFFF);
    render(10'd401, 10'd300, 12'h111, c); chk("frame_right", c, 12'hFFF);
    render(10'd402, 10'd300, 12'h456, c); chk("outside_right_bg", c, 12'h456);
    render(10'd300, 10'd401, 12'h111, c); chk("frame_bottom", c, 12'hFFF);
    render(10'd300, 10'd402, 12'h789, c); chk("outside_bottom_bg", c, 12'h789);
    render(10'd399, 10'd85, 12'h246, c);
`ifdef GRID_LINES_EN
    chk("empty_edge_grid", c, 12'h333);
`else
    chk("empty_edge_bg", c, 12'h246);
`endif

    x = 10'd392; y = 10'd392;
    wr_en = 1'b1; wr_row = 5'd19; wr_col = 4'd9; wr_cell = 3'd7;
    step;
    wr_en = 1'b0;
    model[199] = 3'd7;
    bg_color = 12'h111;
    step;
    chk("read_first_old", color_out, 12'h111);
    render(10'd392, 10'd392, 12'h222, c); chk("after_write_L", c, 12'hF80);
    render(10'd399, 10'd399, 12'h222, c); chk("L_edge_dark", c, 12'h740);

    wr(20, 0, 3'd3);
    wr(0, 10, 3'd3);
    wr(2, 3, 3'd2);
    wr(5, 5, 3'd3);
    wr(10, 0, 3'd4);
    wr(15, 8, 3'd5);
    wr(7, 2, 3'd6);
    for (int i = 0; i < 200; i++) begin
      render(10'(240 + 16*(i%10) + 8), 10'(80 + 16*(i/10) + 8), 12'h5A5, c);
      chk($sformatf("scan_cell_%0d", i), c, exp_center(model[i], 12'h5A5));
    end

    for (int i = 0; i < 200; i++) wr(i/10, i%10, 3'((i%7) + 1));
    render(10'd248, 10'd88, 12'h000, c);  chk("filled_cell0", c, 12'h0FF);
    render(10'd376, 10'd88, 12'h000, c);  chk("filled_cell8", c, 12'hFF0);

    clear_req = 1'b1;
    step;
    clear_req = 1'b0;
    chk("clear_enter_busy", 12'(busy), 12'h001);
    count_busy(100, n);
    chk("clear_len_no_restart", 12'(n), 12'd200);
    render(10'd248, 10'd88, 12'h3C3, c);  chk("cleared_cell0", c, 12'h3C3);
    render(10'd392, 10'd232, 12'h3C3, c); chk("cleared_cell99", c, 12'h3C3);
    render(10'd392, 10'd392, 12'h3C3, c); chk("cleared_cell199", c, 12'h3C3);
    render(10'd240, 10'd80, 12'h3C3, c);
`ifdef GRID_LINES_EN
    chk("cleared_edge_grid", c, 12'h333);
`else
    chk("cleared_edge_bg", c, 12'h3C3);
`endif

    wr(3, 3, 3'd4);
    clear_req = 1'b1;
    step;
    clear_req = 1'b0;
    repeat (50) step;
    reset = 1'b1;
    #1;
    chk("midclear_reset_busy", 12'(busy), 12'h001);
    chk("midclear_reset_color", color_out, 12'h000);
    step;
    reset = 1'b0;
    count_busy(300, n);
    chk("restart_clear_len", 12'(n), 12'd200);
    render(10'd296, 10'd136, 12'h0A0, c); chk("restart_cleared", c, 12'h0A0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
